// File: rtl/ladder_timer_pkg.sv
// ============================================================================
// Module   : ladder_timer_pkg
// Brief    : Mode encoding shared by the ladder timer bank and its channels.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ladder_timer_pkg;

    typedef logic [1:0] tmr_mode_t;

    localparam tmr_mode_t TMR_TON = 2'd0;
    localparam tmr_mode_t TMR_TOF = 2'd1;
    localparam tmr_mode_t TMR_RTO = 2'd2;
    localparam tmr_mode_t TMR_DIS = 2'd3;

endpackage

`default_nettype wire

// File: rtl/ladder_timer_ch.sv
// ============================================================================
// Module   : ladder_timer_ch
// Brief    : One TON/TOF/RTO ladder timer channel with flags derived from next ACC.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ladder_timer_ch
    import ladder_timer_pkg::*;
#(
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_pulse,
    input  logic             IN,
    input  logic             RES,
    input  tmr_mode_t        MODE,
    input  logic [ACC_W-1:0] PRE,
    output logic             DN,
    output logic             TT,
    output logic             EN,
    output logic [ACC_W-1:0] ACC
);

    localparam logic [ACC_W-1:0] c_one = {{(ACC_W-1){1'b0}}, 1'b1};

    tmr_mode_t        r_mode, w_mode;
    logic [ACC_W-1:0] r_acc, w_acc, w_cnt_acc;
    logic             r_dn, r_tt, r_en;
    logic             w_dn, w_tt, w_en;

    // Counting stops at PRE; a PRE lowered below ACC simply freezes ACC.
    assign w_cnt_acc = (tick_pulse && (r_acc < PRE)) ? r_acc + c_one : r_acc;

    always_comb begin
        w_mode = r_mode;
        w_acc  = r_acc;
        w_dn   = r_dn;
        w_tt   = r_tt;
        w_en   = r_en;
        if (MODE != r_mode) begin
            w_mode = MODE;
            w_acc  = '0;
            w_dn   = 1'b0;
            w_tt   = 1'b0;
            w_en   = IN && (MODE != TMR_DIS);
        end else if (r_mode == TMR_DIS) begin
            w_acc = '0;
            w_dn  = 1'b0;
            w_tt  = 1'b0;
            w_en  = 1'b0;
        end else if (RES) begin
            w_acc = '0;
            w_dn  = 1'b0;
            w_tt  = 1'b0;
            w_en  = IN;
        end else begin
            case (r_mode)
                TMR_TON: begin
                    if (IN) begin
                        w_en  = 1'b1;
                        w_acc = w_cnt_acc;
                        w_dn  = (w_cnt_acc >= PRE);
                        w_tt  = (w_cnt_acc < PRE);
                    end else begin
                        w_acc = '0;
                        w_dn  = 1'b0;
                        w_tt  = 1'b0;
                        w_en  = 1'b0;
                    end
                end
                TMR_TOF: begin
                    if (IN) begin
                        w_acc = '0;
                        w_dn  = 1'b1;
                        w_tt  = 1'b0;
                        w_en  = 1'b1;
                    end else begin
                        w_en = 1'b0;
                        // Only an armed (DN=1) off-delay times out; otherwise hold.
                        if (r_dn) begin
                            w_acc = w_cnt_acc;
                            w_dn  = (w_cnt_acc < PRE);
                            w_tt  = (w_cnt_acc < PRE);
                        end else begin
                            w_tt = 1'b0;
                        end
                    end
                end
                TMR_RTO: begin
                    if (IN) begin
                        w_en  = 1'b1;
                        w_acc = w_cnt_acc;
                        w_dn  = (w_cnt_acc >= PRE);
                        w_tt  = (w_cnt_acc < PRE);
                    end else begin
                        w_en = 1'b0;
                        w_tt = 1'b0;
                    end
                end
                default: begin
                    w_acc = '0;
                    w_dn  = 1'b0;
                    w_tt  = 1'b0;
                    w_en  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= TMR_DIS;
            r_acc  <= '0;
            r_dn   <= 1'b0;
            r_tt   <= 1'b0;
            r_en   <= 1'b0;
        end else begin
            r_mode <= w_mode;
            r_acc  <= w_acc;
            r_dn   <= w_dn;
            r_tt   <= w_tt;
            r_en   <= w_en;
        end
    end

    assign DN  = r_dn;
    assign TT  = r_tt;
    assign EN  = r_en;
    assign ACC = r_acc;

endmodule

`default_nettype wire

// File: rtl/ladder_timer_bank.sv
// ============================================================================
// Module   : ladder_timer_bank
// Brief    : NUM_CH independent ladder timers sharing one 1 kHz tick edge.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ladder_timer_bank
    import ladder_timer_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int ACC_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic [NUM_CH-1:0]       IN,
    input  logic [NUM_CH-1:0]       RES,
    input  logic [2*NUM_CH-1:0]     MODE,
    input  logic [NUM_CH*ACC_W-1:0] PRE,
    output logic [NUM_CH-1:0]       DN,
    output logic [NUM_CH-1:0]       TT,
    output logic [NUM_CH-1:0]       EN,
    output logic [NUM_CH*ACC_W-1:0] ACC
);

    logic r_last_tick;
    logic w_tick_pulse;

    // Reset to 1 so a tick already high when reset releases is not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_tick <= 1'b1;
        end else begin
            r_last_tick <= tick;
        end
    end

    assign w_tick_pulse = tick & ~r_last_tick;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            ladder_timer_ch #(
                .ACC_W (ACC_W)
            ) u_ch (
                .clk        (clk),
                .rst        (rst),
                .tick_pulse (w_tick_pulse),
                .IN         (IN[g]),
                .RES        (RES[g]),
                .MODE       (tmr_mode_t'(MODE[2*g +: 2])),
                .PRE        (PRE[g*ACC_W +: ACC_W]),
                .DN         (DN[g]),
                .TT         (TT[g]),
                .EN         (EN[g]),
                .ACC        (ACC[g*ACC_W +: ACC_W])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_ladder_timer_bank.sv
// ============================================================================
// Module   : tb_ladder_timer_bank
// Brief    : Directed bench for the ladder timer bank (4 channels, 8-bit ACC).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ladder_timer_bank;

    localparam int NUM_CH = 4;
    localparam int ACC_W  = 8;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    tick = 1'b0;
    logic [NUM_CH-1:0]       in_v = '0;
    logic [NUM_CH-1:0]       res_v = '0;
    logic [2*NUM_CH-1:0]     mode_v = '1;
    logic [NUM_CH*ACC_W-1:0] pre_v = '0;
    logic [NUM_CH-1:0]       dn, tt, en;
    logic [NUM_CH*ACC_W-1:0] acc;

    int errors = 0;
    int checks = 0;

    ladder_timer_bank #(
        .NUM_CH (NUM_CH),
        .ACC_W  (ACC_W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .IN   (in_v),
        .RES  (res_v),
        .MODE (mode_v),
        .PRE  (pre_v),
        .DN   (dn),
        .TT   (tt),
        .EN   (en),
        .ACC  (acc)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set0(input logic [1:0] m, input logic [7:0] p, input logic i, input logic r);
        mode_v[1:0] = m;
        pre_v[7:0]  = p;
        in_v[0]     = i;
        res_v[0]    = r;
    endtask

    // One tick pulse: high for one clk (counted at that edge), low for one clk.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            cyc();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        if (acc !== '0) begin errors++; $display("FAIL reset_acc got=%h exp=0", acc); end
        checks++;
        if ({dn, tt, en} !== 12'h000) begin errors++; $display("FAIL reset_flags got=%h exp=000", {dn, tt, en}); end
        checks++;
    endtask

    task automatic test_ton;
        set0(2'd0, 8'd5, 1'b1, 1'b0);
        cyc();
        if ({dn[0], tt[0], en[0]} !== 3'b001) begin errors++; $display("FAIL ton_modechg got=%b exp=001", {dn[0], tt[0], en[0]}); end
        checks++;
        cyc();
        if ({dn[0], tt[0], en[0]} !== 3'b011) begin errors++; $display("FAIL ton_timing got=%b exp=011", {dn[0], tt[0], en[0]}); end
        checks++;
        for (int k = 1; k <= 5; k++) begin
            tick = 1'b1;
            cyc();
            if (acc[7:0] !== 8'(k)) begin errors++; $display("FAIL ton_acc got=%0d exp=%0d", acc[7:0], k); end
            checks++;
            if ({dn[0], tt[0]} !== ((k == 5) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL ton_flags k=%0d got=%b", k, {dn[0], tt[0]}); end
            checks++;
            tick = 1'b0;
            cyc();
        end
        ticks(2);
        if (acc[7:0] !== 8'd5) begin errors++; $display("FAIL ton_hold got=%0d exp=5", acc[7:0]); end
        checks++;
        in_v[0] = 1'b0;
        cyc();
        if ({acc[7:0], dn[0], tt[0], en[0]} !== 11'd0) begin errors++; $display("FAIL ton_off got=%h exp=0", {acc[7:0], dn[0], tt[0], en[0]}); end
        checks++;
    endtask

    task automatic test_tof;
        set0(2'd1, 8'd3, 1'b1, 1'b0);
        cyc(2);
        if ({dn[0], tt[0], en[0]} !== 3'b101) begin errors++; $display("FAIL tof_armed got=%b exp=101", {dn[0], tt[0], en[0]}); end
        checks++;
        in_v[0] = 1'b0;
        cyc();
        if ({dn[0], tt[0], en[0]} !== 3'b110) begin errors++; $display("FAIL tof_timing got=%b exp=110", {dn[0], tt[0], en[0]}); end
        checks++;
        for (int k = 1; k <= 3; k++) begin
            tick = 1'b1;
            cyc();
            if ({acc[7:0], dn[0], tt[0]} !== {8'(k), ((k == 3) ? 2'b00 : 2'b11)}) begin
                errors++; $display("FAIL tof_step k=%0d got=%0d/%b", k, acc[7:0], {dn[0], tt[0]});
            end
            checks++;
            tick = 1'b0;
            cyc();
        end
        ticks(1);
        if (acc[7:0] !== 8'd3) begin errors++; $display("FAIL tof_hold got=%0d exp=3", acc[7:0]); end
        checks++;
        in_v[0] = 1'b1;
        cyc();
        if ({acc[7:0], dn[0]} !== {8'd0, 1'b1}) begin errors++; $display("FAIL tof_reload got=%0d/%b exp=0/1", acc[7:0], dn[0]); end
        checks++;
    endtask

    task automatic test_rto;
        set0(2'd2, 8'd4, 1'b1, 1'b0);
        cyc();
        ticks(2);
        if ({acc[7:0], tt[0]} !== {8'd2, 1'b1}) begin errors++; $display("FAIL rto_run got=%0d/%b exp=2/1", acc[7:0], tt[0]); end
        checks++;
        in_v[0] = 1'b0;
        cyc();
        ticks(5);
        if ({acc[7:0], dn[0], tt[0], en[0]} !== {8'd2, 3'b000}) begin errors++; $display("FAIL rto_retain got=%0d/%b", acc[7:0], {dn[0], tt[0], en[0]}); end
        checks++;
        in_v[0] = 1'b1;
        ticks(2);
        if ({acc[7:0], dn[0], tt[0]} !== {8'd4, 2'b10}) begin errors++; $display("FAIL rto_done got=%0d/%b exp=4/10", acc[7:0], {dn[0], tt[0]}); end
        checks++;
        in_v[0] = 1'b0;
        cyc();
        if ({acc[7:0], dn[0], en[0]} !== {8'd4, 2'b10}) begin errors++; $display("FAIL rto_dn_hold got=%0d/%b exp=4/10", acc[7:0], {dn[0], en[0]}); end
        checks++;
        res_v[0] = 1'b1;
        cyc();
        res_v[0] = 1'b0;
        if ({acc[7:0], dn[0]} !== 9'd0) begin errors++; $display("FAIL rto_res got=%0d/%b exp=0/0", acc[7:0], dn[0]); end
        checks++;
    endtask

    task automatic test_boundaries;
        set0(2'd0, 8'd255, 1'b1, 1'b0);
        cyc();
        ticks(260);
        if ({acc[7:0], dn[0], tt[0]} !== {8'd255, 2'b10}) begin errors++; $display("FAIL sat255 got=%0d/%b exp=255/10", acc[7:0], {dn[0], tt[0]}); end
        checks++;
        in_v[0] = 1'b0;
        cyc();
        set0(2'd0, 8'd10, 1'b1, 1'b0);
        ticks(6);
        pre_v[7:0] = 8'd3;
        cyc();
        if ({acc[7:0], dn[0], tt[0]} !== {8'd6, 2'b10}) begin errors++; $display("FAIL pre_lower got=%0d/%b exp=6/10", acc[7:0], {dn[0], tt[0]}); end
        checks++;
        ticks(1);
        if (acc[7:0] !== 8'd6) begin errors++; $display("FAIL pre_lower_hold got=%0d exp=6", acc[7:0]); end
        checks++;
        in_v[0] = 1'b0;
        cyc();
        set0(2'd0, 8'd0, 1'b1, 1'b0);
        cyc();
        if ({acc[7:0], dn[0], tt[0]} !== {8'd0, 2'b10}) begin errors++; $display("FAIL pre0_ton got=%0d/%b exp=0/10", acc[7:0], {dn[0], tt[0]}); end
        checks++;
    endtask

    task automatic test_priorities;
        in_v[0] = 1'b0;
        cyc();
        set0(2'd0, 8'd10, 1'b1, 1'b0);
        ticks(3);
        mode_v[1:0] = 2'd2;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        if ({acc[7:0], dn[0], tt[0], en[0]} !== {8'd0, 3'b001}) begin errors++; $display("FAIL modechg_prio got=%0d/%b exp=0/001", acc[7:0], {dn[0], tt[0], en[0]}); end
        checks++;
        cyc();
        ticks(2);
        res_v[0] = 1'b1;
        tick = 1'b1;
        cyc();
        if (acc[7:0] !== 8'd0) begin errors++; $display("FAIL res_vs_tick got=%0d exp=0", acc[7:0]); end
        checks++;
        res_v[0] = 1'b0;
        tick = 1'b0;
        cyc();
        ticks(1);
        if (acc[7:0] !== 8'd1) begin errors++; $display("FAIL res_resume got=%0d exp=1", acc[7:0]); end
        checks++;
        ticks(2);
        rst = 1'b1;
        cyc();
        if ({acc, dn, tt, en} !== '0) begin errors++; $display("FAIL rst_midcount got=%h exp=0", {acc, dn, tt, en}); end
        checks++;
        set0(2'd0, 8'd10, 1'b1, 1'b0);
        tick = 1'b1;
        cyc();
        rst = 1'b0;
        cyc(3);
        tick = 1'b0;
        if (acc[7:0] !== 8'd0) begin errors++; $display("FAIL tick_at_release got=%0d exp=0", acc[7:0]); end
        checks++;
    endtask

    task automatic test_multi;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        mode_v = {2'd3, 2'd2, 2'd1, 2'd0};
        pre_v  = {8'd1, 8'd3, 8'd2, 8'd2};
        in_v   = 4'b1111;
        res_v  = 4'b0000;
        cyc(2);
        in_v[1] = 1'b0;
        cyc();
        if ({dn, tt} !== {4'b0010, 4'b0111}) begin errors++; $display("FAIL multi_start got=%b exp=00100111", {dn, tt}); end
        checks++;
        if (en !== 4'b0101) begin errors++; $display("FAIL multi_en got=%b exp=0101", en); end
        checks++;
        ticks(3);
        if (acc !== {8'd0, 8'd3, 8'd2, 8'd2}) begin errors++; $display("FAIL multi_acc got=%h exp=00030202", acc); end
        checks++;
        if ({dn, tt, en} !== {4'b0101, 4'b0000, 4'b0101}) begin errors++; $display("FAIL multi_flags got=%b exp=010100000101", {dn, tt, en}); end
        checks++;
    endtask

    initial begin
        test_reset();
        test_ton();
        test_tof();
        test_rto();
        test_boundaries();
        test_priorities();
        test_multi();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/ladder_timer_bank.md
Name: ladder_timer_bank

Overview:
Bank of NUM_CH independent ladder-logic timers that share one 1 kHz tick (1 ms per tick).
Each channel runs in TON (on-delay), TOF (off-delay) or RTO (retentive on-delay) mode, selected at run time.
It is the parametrised successor of the single TON timer: configurable width, per-channel reset input and output flags that agree with ACC in the same cycle.
It sits between the rung-evaluation logic and the PLC I/O image.

Parameters:
NUM_CH, 4, number of timer channels (1..32).
ACC_W, 32, width in bits of PRE and ACC per channel (8..32).

Ports:
clk  in  1  system clock.
rst  in  1  reset; synchronous, active-high.
tick  in  1  slowed-down clock at 1 kHz, asynchronous to rung logic but sampled on clk.
IN  in  NUM_CH  per-channel rung condition (timer input).
RES  in  NUM_CH  per-channel timer reset (RES instruction).
MODE  in  2*NUM_CH  per-channel mode; channel i uses bits [2i+1:2i].
PRE  in  NUM_CH*ACC_W  per-channel preset in ms; channel i uses bits [i*ACC_W +: ACC_W].
DN  out  NUM_CH  per-channel done flag.
TT  out  NUM_CH  per-channel timer-timing flag.
EN  out  NUM_CH  per-channel enable flag.
ACC  out  NUM_CH*ACC_W  per-channel accumulated ms, packed the same way as PRE.

Behaviour:
- All state updates on posedge clk.
- rst=1 forces the following on that edge: ACC=0, DN=0, TT=0, EN=0 for all channels, last_tick=1, and the stored mode of every channel = 3.
- last_tick resets to 1 so that a tick already high at reset release does not count.
- Tick edge: tick_pulse = tick & ~last_tick; last_tick <= tick every cycle. Exactly one count per tick rising edge.
- Mode encoding:
  - 0 TON, 1 TOF, 2 RTO.
  - 3 DISABLED: ACC=0, DN=TT=EN=0, and RES and IN are ignored.
- Mode change:
  - Each channel registers its MODE.
  - If incoming MODE differs from the stored mode, that cycle sets ACC=0, DN=TT=0, EN=IN, and the new mode is stored. No count happens that cycle.
- Flag consistency: DN and TT are computed from the next ACC value. After any edge, DN, TT and ACC are mutually consistent, with no one-cycle lag.
- Saturation:
  - ACC never exceeds PRE by counting and never wraps.
  - If PRE is lowered below ACC, ACC holds its value; it is not clipped.
- TON:
  - IN=0: ACC=0, DN=TT=EN=0.
  - IN=1: EN=1. On tick_pulse with ACC<PRE, ACC+1. DN = (ACC_next>=PRE); TT = IN & (ACC_next<PRE).
  - PRE=0 with IN=1: DN=1 on the first edge.
- TOF:
  - IN=1: ACC=0, DN=1, EN=1, TT=0.
  - IN=0: EN=0. If DN=1, count on tick_pulse. While ACC_next<PRE: TT=1, DN=1. When ACC_next>=PRE: DN=0, TT=0.
  - After rst, DN=0 until IN has been high once.
  - PRE=0: DN drops on the first edge with IN=0.
- RTO:
  - IN=1: EN=1 and counting as in TON.
  - IN=0: EN=0, TT=0, and ACC and DN are held.
  - DN stays 1 until RES.
- RES=1 (modes 0-2):
  - Clears ACC, DN and TT on that edge; EN = IN.
  - RES has priority over counting and over the TOF IN=1 load of DN=1.
  - Counting resumes on the first tick_pulse after RES falls.
- Simultaneous events, by priority: rst > mode change > RES > normal mode behaviour.
- Channels are fully independent except for the shared tick_pulse.

Decomposition:
- Package ladder_timer_pkg: mode constants TMR_TON=2'd0, TMR_TOF=2'd1, TMR_RTO=2'd2, TMR_DIS=2'd3, and a 2-bit tmr_mode_t typedef.
- The top level holds the tick edge detector and a generate loop.
- Sub-module ladder_timer_ch (one channel; parameter ACC_W; inputs tick_pulse, IN, RES, MODE, PRE; outputs DN, TT, EN, ACC; same clk/rst).

Test Plan:
1. TON, PRE=5, IN=1 from cycle 0, tick period 10 clk -> ACC steps 1..5 one clk after each tick rise. DN=1 and TT=0 on the same edge ACC=5. ACC holds at 5; IN=0 -> all outputs 0 next edge.
2. TOF, PRE=3: IN=1 -> DN=1, EN=1. IN=0 -> TT=1, ACC 1,2,3 on ticks. DN=0 and TT=0 on the edge ACC=3. IN=1 again -> ACC=0, DN=1.
3. RTO, PRE=4: IN high for 2 ticks (ACC=2), low for 5 ticks (ACC stays 2, TT=0, EN=0), high for 2 ticks -> ACC=4, DN=1. IN=0 -> DN stays 1. RES=1 -> ACC=0, DN=0.
4. Boundaries:
   - TON with PRE=0 -> DN=1 on the first edge.
   - ACC_W=8, PRE=255 -> ACC saturates at 255, no wrap.
   - PRE lowered from 10 to 3 at ACC=6 -> ACC holds 6, DN=1.
5. Priorities:
   - MODE change TON->RTO at ACC=3 -> ACC=0 and flags cleared that edge.
   - RES and tick_pulse in the same cycle -> ACC=0.
   - rst asserted mid-count -> all outputs 0 next edge.
   - tick high at rst release -> no count.
6. Multi-channel, NUM_CH=4 with different modes and PRE values -> each channel matches its single-channel reference model, and MODE=3 channels stay all-zero.
